// File: rtl/nios_upc_nios2_qsys_0_oci_dct_drain.sv
// rtl/nios_upc_nios2_qsys_0_oci_dct_drain.sv - drains captured DCT trace buffers one code per transfer
// Active shift register plus a single-entry hold slot for back-to-back buffers.
module nios_upc_nios2_qsys_0_oci_dct_drain #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CODE_W*DEPTH-1:0]   dct_buffer,
  input  logic [CNT_W-1:0]          dct_count,
  input  logic                      dct_load,
  output logic                      dct_ready,
  input  logic                      flush,
  output logic [CODE_W-1:0]         code_data,
  output logic                      code_valid,
  input  logic                      code_ready,
  output logic                      code_last,
  output logic                      busy,
  output logic                      overflow,
  output logic [7:0]                frame_count
);

  localparam int BUF_W = CODE_W * DEPTH;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [BUF_W-1:0]   act_data, act_data_n;
  logic [CNT_W-1:0]   act_rem, act_rem_n;
  logic [BUF_W-1:0]   hold_data, hold_data_n;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
  logic               hold_valid, hold_valid_n;
  logic               overflow_n;
  logic [7:0]         frame_n;

  logic accept, load_nz, xfer, last_xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      act_data    <= '0;
      act_rem     <= '0;
      hold_data   <= '0;
      hold_cnt    <= '0;
      hold_valid  <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state       <= state_n;
      act_data    <= act_data_n;
      act_rem     <= act_rem_n;
      hold_data   <= hold_data_n;
      hold_cnt    <= hold_cnt_n;
      hold_valid  <= hold_valid_n;
      overflow    <= overflow_n;
      frame_count <= frame_n;
    end
  end

  always_comb begin
    dct_ready  = !hold_valid && !reset;
    code_valid = (state == SHIFT);
    code_data  = code_valid ? act_data[CODE_W-1:0] : '0;
    code_last  = code_valid && (act_rem == CNT_W'(1));
    busy       = code_valid || hold_valid;

    accept    = dct_load && dct_ready && !flush;
    load_nz   = accept && (dct_count != '0);
    xfer      = code_valid && code_ready;
    last_xfer = xfer && (act_rem == CNT_W'(1));

    state_n      = state;
    act_data_n   = act_data;
    act_rem_n    = act_rem;
    hold_data_n  = hold_data;
    hold_cnt_n   = hold_cnt;
    hold_valid_n = hold_valid;
    frame_n      = frame_count;
    overflow_n   = overflow || (dct_load && !dct_ready && !flush);

    // flush wins over any load or transfer in the same cycle, and never counts a frame
    if (flush) begin
      state_n      = IDLE;
      hold_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_nz) begin
            act_data_n = dct_buffer;
            act_rem_n  = dct_count;
            state_n    = SHIFT;
          end
        end
        SHIFT: begin
          if (last_xfer) begin
            frame_n = frame_count + 8'd1;
            if (hold_valid) begin
              act_data_n   = hold_data;
              act_rem_n    = hold_cnt;
              hold_valid_n = 1'b0;
            end else if (load_nz) begin
              act_data_n = dct_buffer;
              act_rem_n  = dct_count;
            end else begin
              state_n = IDLE;
            end
          end else begin
            if (xfer) begin
              act_data_n = act_data >> CODE_W;
              act_rem_n  = act_rem - CNT_W'(1);
            end
            if (load_nz) begin
              hold_data_n  = dct_buffer;
              hold_cnt_n   = dct_count;
              hold_valid_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      assert (int'(dct_count) <= DEPTH);
    end
  end

endmodule

// File: doc/nios_upc_nios2_qsys_0_oci_dct_drain.md
# nios_upc_nios2_qsys_0_oci_dct_drain

Read-side counterpart of the OCI debug-capture trace (DCT) buffer. The capture logic fills a 30-bit buffer with up to fifteen 2-bit trace codes and tracks the fill level in a 4-bit count. This block takes a completed buffer from that logic, holds one more in a skid slot, and drains the codes one per transfer onto a valid/ready stream toward the trace FIFO. It sits between the OCI capture logic and the trace FIFO.

## Interface

Parameters:
- CODE_W, 2, width of one trace code
- DEPTH, 15, codes per buffer; buffer width is CODE_W*DEPTH = 30
- CNT_W, 4, width of the count input

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- dct_buffer  in  30  packed codes; entry i is at bits [2i+1:2i]; entry 0 is the oldest
- dct_count  in  4  number of valid entries, 0..15
- dct_load  in  1  single-cycle offer of dct_buffer/dct_count
- dct_ready  out  1  a load will be accepted this cycle
- flush  in  1  discard all buffered data
- code_data  out  2  current trace code
- code_valid  out  1  code_data is valid
- code_ready  in  1  downstream accepts code_data
- code_last  out  1  code_data is the final entry of its buffer
- busy  out  1  shift or hold register occupied
- overflow  out  1  sticky: a dct_load arrived while dct_ready=0
- frame_count  out  8  buffers fully drained, wraps modulo 256

## Operation

Storage:
- Active register: shift data, remaining count, and act_valid.
- Hold register: buffer, count, and hold_valid.

Control:
- dct_ready = !hold_valid && !reset.
- Accept condition: dct_load && dct_ready && !flush.

States:
- IDLE (act_valid=0):
  - An accepted load with count>0 goes into the active register; go to SHIFT.
  - An accepted load with count=0 is discarded. It produces no codes and does not change frame_count.
- SHIFT (act_valid=1):
  - code_valid=1; code_data = active bits [1:0].
  - code_last=1 when remaining=1.
  - On each transfer (code_valid && code_ready): shift right by CODE_W and decrement remaining.
  - While in SHIFT, an accepted load with count>0 goes into the hold register.
- Last transfer (remaining=1 and transfer):
  - frame_count increments.
  - If hold_valid=1: hold moves into the active register and hold_valid clears. Stay in SHIFT.
  - Else, if an accepted load with count>0 arrives the same cycle: it goes directly into the active register. Stay in SHIFT.
  - Else: go to IDLE.
- Outputs:
  - busy = act_valid || hold_valid.
  - overflow sets on dct_load && !dct_ready && !reset && !flush. It clears only on reset.
  - A rejected load is dropped.
- flush:
  - Clears act_valid and hold_valid in the same edge and forces IDLE.
  - Takes priority over a simultaneous load and transfer.
  - frame_count is unchanged, including when the transfer of a last code coincides with flush.
  - Does not clear overflow.
- Counts above DEPTH cannot occur because CNT_W=4 and DEPTH=15. Assertion: dct_count <= DEPTH on every accepted load.

## Timing

- Reset values: code_valid=0, code_last=0, code_data=0, busy=0, overflow=0, frame_count=0, state IDLE. dct_ready=0 while reset is high and 1 on the first cycle after reset.
- Load latency: a load accepted in cycle N while IDLE gives code_valid=1 in cycle N+1 with entry 0.
- Throughput: one code per cycle while code_ready=1. A buffer with count=k takes k transfer cycles.
- Back-to-back buffers:
  - The hold to active handover happens at the edge of the last transfer.
  - code_valid stays 1 with zero bubble.
  - The new buffer's entry 0 appears in the next cycle.
- Stall: while code_valid && !code_ready, code_data and code_last are held stable. code_valid does not drop.
- dct_ready rises the cycle after the hold register empties.
- dct_ready falls the cycle after a load is captured into hold.
- Reset mid-drain: all state is cleared at that edge and no further codes are emitted.

## Test plan

- Reset then single load: dct_buffer=30'h0000_1B (codes 3,2,1,0), count=4, code_ready=1.
  - code_data must be 3,2,1,0 in cycles N+1..N+4.
  - code_last=1 only in N+4.
  - frame_count=1; busy returns to 0 in N+5.
- Back-to-back loads: load A (count=3), then load B (count=2) while A is draining.
  - Five consecutive valid cycles with no bubble.
  - code_last asserts on A's entry 2 and on B's entry 1.
  - dct_ready=0 from the cycle after B is captured until B moves to active.
- Backpressure: count=2, code_ready held 0 for 5 cycles.
  - code_data stays at entry 0 and code_valid stays 1.
  - Draining completes 2 cycles after code_ready rises.
- Overflow: active and hold both full, third dct_load arrives.
  - overflow=1 from the next cycle and stays 1.
  - The third buffer is never emitted.
  - frame_count advances by exactly 2.
- Count 0 and flush:
  - A load with count=0 produces no code_valid and leaves frame_count unchanged.
  - flush in the middle of a count=10 drain: code_valid=0 in the next cycle, busy=0, frame_count unchanged.
- Reset mid-drain with hold full:
  - All outputs return to their reset values the next cycle.
  - A subsequent load with count=1 drains normally, giving frame_count=1.
